// File: rtl/led_pattern_seq.sv
// led_pattern_seq: generates the LED patterns for the board LED output stage.
//
// A prescaler divides clk down to a step. On each step the current pattern
// advances by one. There are four patterns: rotate, bounce, binary count and
// blink. With en=0 the prescaler holds its count, and a step pulse advances
// the pattern by one step.
//
// Optional feature (macro LED_PWM_EN): a free-running PWM counter gates the
// pattern using duty. When the macro is undefined, duty is ignored and no PWM
// counter is built.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   en    in   1 = free-run on prescaler tick, 0 = hold (single-step allowed)
//   mode  in   2  00 rotate, 01 bounce, 10 binary count, 11 blink
//   step  in   single-step pulse, honoured only while en=0
//   duty  in   PWM_W  brightness duty (LED_PWM_EN builds only)
//   leds  out  5  LED drive, leds[0]=d1 ... leds[4]=d5 (registered)
//   tick  out  1-cycle pulse in the cycle a new pattern value appears
module led_pattern_seq #(
  parameter int unsigned DIV   = 12000000,
  parameter int unsigned DIV_W = 24,
  parameter int unsigned PWM_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic [PWM_W-1:0] duty,
  output logic [4:0]       leds,
  output logic             tick
);

  // The FSM state is the active mode. It is held in state_q, so a checker
  // can observe it directly.
  typedef enum logic [1:0] {
    ST_ROTATE = 2'b00,
    ST_BOUNCE = 2'b01,
    ST_BINARY = 2'b10,
    ST_BLINK  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic             dir_down_q, dir_down_d;  // bounce direction, 0 = UP
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [4:0]       pattern_q, pattern_d;
  logic             tick_q, tick_d;

  logic             presc_wrap;
  logic             adv;
  logic             mode_chg;
  logic             is_onehot;
  logic             eff_up;
  logic [4:0]       bounce_next;

  assign presc_wrap = (presc_q == DIV_W'(DIV - 1));
  assign adv        = en ? presc_wrap : step;
  assign mode_chg   = (mode != state_q);
  assign is_onehot  = (pattern_q != 5'd0) &&
                      ((pattern_q & (pattern_q - 5'd1)) == 5'd0);

  // At either end the bounce direction is forced, so the shift can never
  // leave the one-hot range, even if dir_down_q disagrees with the pattern.
  always_comb begin
    eff_up = ~dir_down_q;
    if (pattern_q == 5'b00001) eff_up = 1'b1;
    if (pattern_q == 5'b10000) eff_up = 1'b0;
    bounce_next = eff_up ? {pattern_q[3:0], 1'b0} : {1'b0, pattern_q[4:1]};
  end

  always_comb begin
    state_d    = state_q;
    dir_down_d = dir_down_q;
    presc_d    = presc_q;
    pattern_d  = pattern_q;
    tick_d     = 1'b0;

    if (en) presc_d = presc_wrap ? '0 : presc_q + DIV_W'(1);

    if (mode_chg) begin
      // A mode change wins over a coincident advance. It restarts the
      // prescaler and reloads the initial pattern of the new mode.
      state_d    = state_e'(mode);
      presc_d    = '0;
      dir_down_d = 1'b0;
      pattern_d  = (mode[1] == 1'b0) ? 5'b00001 : 5'b00000;
    end else if (adv) begin
      tick_d = 1'b1;
      case (state_q)
        ST_ROTATE: begin
          pattern_d = is_onehot ? {pattern_q[3:0], pattern_q[4]} : 5'b00001;
        end
        ST_BOUNCE: begin
          if (!is_onehot) begin
            pattern_d  = 5'b00001;
            dir_down_d = 1'b0;
          end else begin
            pattern_d  = bounce_next;
            dir_down_d = ~eff_up;
            if (bounce_next == 5'b10000) dir_down_d = 1'b1;
            if (bounce_next == 5'b00001) dir_down_d = 1'b0;
          end
        end
        ST_BINARY: pattern_d = pattern_q + 5'd1;
        default:   pattern_d = ~pattern_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ROTATE;
      dir_down_q <= 1'b0;
      presc_q    <= '0;
      pattern_q  <= 5'b00001;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_down_q <= dir_down_d;
      presc_q    <= presc_d;
      pattern_q  <= pattern_d;
      tick_q     <= tick_d;
    end
  end

  assign tick = tick_q;

`ifdef LED_PWM_EN
  // The gated value is registered, so duty has no combinational path to
  // leds. The gate uses the counter value of the current cycle.
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [4:0]       leds_q, leds_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    leds_d    = pattern_d & {5{pwm_cnt_q < duty}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      leds_q    <= 5'b00001;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      leds_q    <= leds_d;
    end
  end

  assign leds = leds_q;
`else
  logic unused_duty;
  assign unused_duty = ^duty;
  assign leds        = pattern_q;
`endif

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq in the default build, with DIV=4.
// The reference model keeps the pattern as a position within each mode's
// cyclic sequence and looks up the expected LED value from that position.
module tb_led_pattern_seq;

  localparam int DIV = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       step;
  logic [1:0] mode;
  logic [3:0] duty;
  logic [4:0] leds;
  logic       tick;

  always #5 clk = ~clk;

  led_pattern_seq #(.DIV(DIV), .DIV_W(3), .PWM_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .step (step),
    .duty (duty),
    .leds (leds),
    .tick (tick)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  int   m_mode  = 0;
  int   m_cnt   = 0;
  int   m_phase = 0;
  logic m_tick  = 1'b0;

  function automatic int period(input int md);
    case (md)
      0:       return 5;
      1:       return 8;
      2:       return 32;
      default: return 2;
    endcase
  endfunction

  function automatic logic [4:0] model_leds(input int md, input int ph);
    case (md)
      0:       return 5'(1 << ph);
      1:       return (ph <= 4) ? 5'(1 << ph) : 5'(1 << (8 - ph));
      2:       return 5'(ph);
      default: return (ph != 0) ? 5'b11111 : 5'b00000;
    endcase
  endfunction

  task automatic model_step();
    logic adv;
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_phase = 0; m_tick = 1'b0;
    end else if (int'(mode) != m_mode) begin
      m_mode = int'(mode); m_cnt = 0; m_phase = 0; m_tick = 1'b0;
    end else begin
      adv = en ? (m_cnt == DIV - 1) : step;
      if (en) m_cnt = (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
      if (adv) m_phase = (m_phase + 1) % period(m_mode);
      m_tick = adv;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs are driven before a rising edge and DUT outputs are sampled 1
  // time unit after it. After sampling, the task returns at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("leds", leds, model_leds(m_mode, m_phase));
    check("tick", {4'b0, tick}, {4'b0, m_tick});
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; step = 1'b0; mode = 2'b00; duty = 4'd0;

    // reset
    cycle(); cycle();
    check("rst_leds", leds, 5'b00001);
    check("rst_tick", {4'b0, tick}, 5'd0);

    // rotate: 5 ticks in 20 cycles return to 00001
    rst = 1'b0;
    repeat (20) cycle();
    check("rot_wrap", leds, 5'b00001);
    check("rot_tick", {4'b0, tick}, 5'd1);

    // bounce: 9 ticks after entering mode 01
    mode = 2'b01;
    cycle();
    check("bnc_init", leds, 5'b00001);
    repeat (36) cycle();
    check("bnc_9", leds, 5'b00010);

    // binary single-step
    en = 1'b0; mode = 2'b10;
    cycle();
    check("bin_init", leds, 5'b00000);
    for (int i = 1; i <= 33; i++) begin
      step = 1'b1; cycle();
      step = 1'b0; cycle();
      if (i == 1)  check("bin_1", leds, 5'b00001);
      if (i == 31) check("bin_31", leds, 5'b11111);
      if (i == 32) check("bin_32", leds, 5'b00000);
      if (i == 33) check("bin_33", leds, 5'b00001);
    end
    en = 1'b1; step = 1'b1;
    cycle();
    step = 1'b0;
    check("step_en_leds", leds, 5'b00001);
    check("step_en_tick", {4'b0, tick}, 5'd0);

    // a mode change in the prescaler terminal cycle wins over the advance
    mode = 2'b00;
    cycle();
    repeat (8) cycle();
    check("mc_pre", leds, 5'b00100);
    repeat (3) cycle();
    mode = 2'b11;
    cycle();
    check("mc_leds", leds, 5'b00000);
    check("mc_tick", {4'b0, tick}, 5'd0);
    repeat (3) cycle();
    check("mc_hold", leds, 5'b00000);
    cycle();
    check("mc_next", leds, 5'b11111);
    check("mc_next_tick", {4'b0, tick}, 5'd1);

    // reset mid-bounce while moving down
    mode = 2'b01;
    cycle();
    repeat (20) cycle();
    check("rm_pre", leds, 5'b01000);
    rst = 1'b1;
    cycle();
    check("rm_leds", leds, 5'b00001);
    check("rm_tick", {4'b0, tick}, 5'd0);
    rst = 1'b0;
    cycle();
    repeat (4) cycle();
    check("rm_up", leds, 5'b00010);

    // randomized run against the model
    repeat (3000) begin
      rst  = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 3) != 0);
      step = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
      duty = 4'($urandom);
      cycle();
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
- Pattern generator that sits directly upstream of the board LED output stage and drives its 5 LED inputs (d1..d5).
- A prescaler divides clk down to a step tick.
- A small mode state machine advances one of four LED patterns on each tick.
- Provides free-running and single-step operation so the LED stage can be exercised in short simulations.

Parameters:
- DIV, 12000000, prescaler terminal count (clk cycles per step); 12 MHz board clock gives 1 step/s; minimum 2.
- DIV_W, 24, prescaler counter width; must satisfy 2^DIV_W >= DIV.
- PWM_W, 4, PWM counter/duty width (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  1 = free-run on prescaler tick; 0 = hold, single-step allowed.
- mode  input  2  00 rotate, 01 bounce, 10 binary count, 11 blink.
- step  input  1  single-step request, 1-cycle pulse; honoured only when en=0.
- duty  input  PWM_W  brightness duty; ignored unless LED_PWM_EN is defined.
- leds  output  5  LED drive; leds[0]=d1 ... leds[4]=d5.
- tick  output  1  1-cycle pulse on every pattern advance.

Behaviour:
- Reset:
  - Synchronous, checked on the clk rising edge, dominates all other inputs.
  - leds=5'b00001, tick=0, prescaler=0, cur_mode=00, dir=UP, PWM counter=0.
- Prescaler:
  - Increments only while en=1. On reaching DIV-1 it wraps to 0 and raises an internal adv for that cycle.
  - While en=0 it holds its value.
- Advance source: adv = (en & prescaler==DIV-1) | (~en & step).
  - step while en=1 is ignored.
- Pattern update: leds update on the clk edge that samples adv. tick is registered and asserts in the same cycle the new leds value appears (1-cycle latency from adv).
- Mode change detection:
  - mode is compared to cur_mode every cycle.
  - On a mismatch: cur_mode<=mode, prescaler<=0, dir<=UP, leds<=init(mode), tick=0.
  - Any coincident adv is discarded (mode change wins).
  - init values: rotate 00001, bounce 00001, binary 00000, blink 00000.
- State machine states = cur_mode (ROTATE, BOUNCE, BINARY, BLINK), plus a dir flag for BOUNCE. Per advance:
  - ROTATE: leds <= {leds[3:0],leds[4]}; 10000 wraps to 00001.
  - BOUNCE:
    - One-hot shift. dir=UP shifts left; dir=DOWN shifts right.
    - On reaching 10000, dir<=DOWN; on reaching 00001, dir<=UP.
    - Period is 8 steps: 00001,00010,00100,01000,10000,01000,...
  - BINARY: leds <= leds+1 mod 32; 11111 wraps to 00000.
  - BLINK: leds <= ~leds (00000 <-> 11111).
- Illegal or non-one-hot leds in ROTATE/BOUNCE cannot occur. If forced, the next advance reloads 00001.
- en toggling does not reset pattern or prescaler; a run resumes from the held count.
- leds and tick are fully registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: LED_PWM_EN.
- Defined:
  - A free-running PWM_W-bit counter runs on clk and is reset to 0 by rst.
  - Output leds = pattern & {5{pwm_cnt < duty}}.
  - duty=0 gives all LEDs off; duty=2^PWM_W-1 gives on for all but 1 cycle in 2^PWM_W.
  - tick and pattern sequencing are unaffected.
- Not defined: duty is ignored, leds = pattern directly, no PWM counter is synthesised.

Test Plan:
- Reset/rotate (DIV=4): rst high 2 cycles, mode=00, en=1 -> leds=00001 after reset; tick every 4th cycle; leds 00010, 00100, 01000, 10000, then 00001 on the 5th tick.
- Bounce (DIV=4, mode=01, en=1): over 9 ticks -> leds 00010, 00100, 01000, 10000, 01000, 00100, 00010, 00001, 00010.
- Binary wrap/step (en=0, mode=10): 33 step pulses -> leds 00001 after the 1st; 11111 after the 31st; 00000 after the 32nd; 00001 after the 33rd; tick once per step. step with en=1 -> no extra advance.
- Mode change vs tick (DIV=4, mode=00, leds=00100): switch to mode=11 in the cycle where the prescaler equals 3 -> leds=00000, no tick, prescaler=0; next tick gives 11111.
- Reset mid-run: assert rst during BOUNCE with dir=DOWN and leds=01000 -> next cycle leds=00001, tick=0, cur_mode=00; after release with mode=01, leds reloads 00001 and dir=UP.
- PWM (LED_PWM_EN, PWM_W=4, mode=11, leds pattern 11111): duty=4 -> leds=11111 for 4 of every 16 clk cycles, else 00000; duty=0 -> constant 00000.
